// File: rtl/br_predictor_param.sv
// rtl/br_predictor_param.sv - fetch-stage branch predictor: direct-mapped BTB, 2-bit PHT, circular RAS
// Optional gshare PHT indexing with global history when BPU_GSHARE_EN is defined.
module br_predictor_param #(
    parameter int BTB_IDX_W = 6,
    parameter int PHT_IDX_W = 6,
    parameter int RAS_DEPTH = 4,
    parameter int GHR_W     = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_pc_valid,
    input  logic [63:0] io_pc,
    output logic        io_pre_valid,
    output logic [63:0] io_pre_next_pc,
    input  logic        io_br_info_valid,
    input  logic        io_br_info_mispredict,
    input  logic [63:0] io_br_info_br_pc,
    input  logic        io_br_info_taken,
    input  logic [63:0] io_br_info_target_next_pc,
    input  logic [1:0]  io_br_info_br_type
);

    localparam int BTB_N     = 1 << BTB_IDX_W;
    localparam int PHT_N     = 1 << PHT_IDX_W;
    localparam int TAG_W     = 62 - BTB_IDX_W;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_CALL = 2'd1,
        BR_RET  = 2'd2,
        BR_JUMP = 2'd3
    } br_type_e;

    logic                 btb_valid  [BTB_N];
    logic [TAG_W-1:0]     btb_tag    [BTB_N];
    logic [63:0]          btb_target [BTB_N];
    br_type_e             btb_type   [BTB_N];
    logic [1:0]           pht        [PHT_N];
    logic [63:0]          ras        [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [RAS_CNT_W-1:0] ras_cnt;

    logic [BTB_IDX_W-1:0] lk_btb_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic [PHT_IDX_W-1:0] lk_pht_idx;
    logic                 lk_hit;
    br_type_e             lk_type;
    logic [63:0]          ras_top;
    logic                 ras_empty;
    logic                 ras_full;
    logic                 do_push;
    logic                 do_pop;

    logic [BTB_IDX_W-1:0] up_btb_idx;
    logic [TAG_W-1:0]     up_tag;
    logic [PHT_IDX_W-1:0] up_pht_idx;
    br_type_e             up_type;
    logic                 up_flush;

    // Low PC bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{io_pc[1:0], io_br_info_br_pc[1:0]};

    assign lk_btb_idx = io_pc[BTB_IDX_W+2:3];
    assign lk_tag     = {io_pc[63:BTB_IDX_W+3], io_pc[2]};
    assign up_btb_idx = io_br_info_br_pc[BTB_IDX_W+2:3];
    assign up_tag     = {io_br_info_br_pc[63:BTB_IDX_W+3], io_br_info_br_pc[2]};
    assign up_type    = br_type_e'(io_br_info_br_type);
    assign up_flush   = io_br_info_valid && io_br_info_mispredict;

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    // Lookup and update both hash with the history as it stands before this cycle's shift.
    assign lk_pht_idx = io_pc[PHT_IDX_W+2:3] ^ PHT_IDX_W'(ghr);
    assign up_pht_idx = io_br_info_br_pc[PHT_IDX_W+2:3] ^ PHT_IDX_W'(ghr);

    always_ff @(posedge clock) begin
        if (reset) begin
            ghr <= '0;
        end else if (io_br_info_valid && up_type == BR_COND) begin
            ghr <= GHR_W'({ghr, io_br_info_taken});
        end
    end
`else
    localparam int unused_ghr_w = GHR_W;

    assign lk_pht_idx = io_pc[PHT_IDX_W+2:3];
    assign up_pht_idx = io_br_info_br_pc[PHT_IDX_W+2:3];
`endif

    assign lk_hit    = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
    assign lk_type   = btb_type[lk_btb_idx];
    assign ras_top   = ras[ras_ptr - RAS_PTR_W'(1)];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == RAS_CNT_W'(RAS_DEPTH));

    always_comb begin
        io_pre_valid   = 1'b0;
        io_pre_next_pc = 64'd0;
        do_push        = 1'b0;
        do_pop         = 1'b0;
        if (lk_hit) begin
            if (lk_type == BR_COND) begin
                io_pre_valid = pht[lk_pht_idx][1];
            end else begin
                io_pre_valid = 1'b1;
            end
        end
        if (io_pre_valid) begin
            if (lk_type == BR_RET && !ras_empty) begin
                io_pre_next_pc = ras_top;
            end else begin
                io_pre_next_pc = btb_target[lk_btb_idx];
            end
            do_push = io_pc_valid && (lk_type == BR_CALL);
            do_pop  = io_pc_valid && (lk_type == BR_RET) && !ras_empty;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (up_flush) begin
            btb_valid[up_btb_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only visible behind a set valid bit.
    always_ff @(posedge clock) begin
        if (!reset && up_flush) begin
            btb_tag[up_btb_idx]    <= up_tag;
            btb_target[up_btb_idx] <= io_br_info_target_next_pc;
            btb_type[up_btb_idx]   <= up_type;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (io_br_info_valid && up_type == BR_COND) begin
            if (io_br_info_taken) begin
                if (pht[up_pht_idx] != 2'b11) begin
                    pht[up_pht_idx] <= pht[up_pht_idx] + 2'd1;
                end
            end else if (pht[up_pht_idx] != 2'b00) begin
                pht[up_pht_idx] <= pht[up_pht_idx] - 2'd1;
            end
        end
    end

    // A resolved mispredict invalidates speculative call history, so it wins over push/pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= 64'd0;
            end
        end else if (up_flush) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (do_push) begin
            ras[ras_ptr] <= io_pc + 64'd4;
            ras_ptr      <= ras_ptr + RAS_PTR_W'(1);
            if (!ras_full) begin
                ras_cnt <= ras_cnt + RAS_CNT_W'(1);
            end
        end else if (do_pop) begin
            ras_ptr <= ras_ptr - RAS_PTR_W'(1);
            ras_cnt <= ras_cnt - RAS_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_br_predictor_param.sv
// tb/tb_br_predictor_param.sv - vector table, directed corners and reference-model random test for br_predictor_param
module tb_br_predictor_param;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_pc_valid;
    logic [63:0] io_pc;
    logic        io_pre_valid;
    logic [63:0] io_pre_next_pc;
    logic        io_br_info_valid;
    logic        io_br_info_mispredict;
    logic [63:0] io_br_info_br_pc;
    logic        io_br_info_taken;
    logic [63:0] io_br_info_target_next_pc;
    logic [1:0]  io_br_info_br_type;

    br_predictor_param dut (
        .clock                     (clock),
        .reset                     (reset),
        .io_pc_valid               (io_pc_valid),
        .io_pc                     (io_pc),
        .io_pre_valid              (io_pre_valid),
        .io_pre_next_pc            (io_pre_next_pc),
        .io_br_info_valid          (io_br_info_valid),
        .io_br_info_mispredict     (io_br_info_mispredict),
        .io_br_info_br_pc          (io_br_info_br_pc),
        .io_br_info_taken          (io_br_info_taken),
        .io_br_info_target_next_pc (io_br_info_target_next_pc),
        .io_br_info_br_type        (io_br_info_br_type)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pcv;
        logic [63:0] pc;
        logic        brv;
        logic        misp;
        logic        taken;
        logic [63:0] br_pc;
        logic [63:0] tgt;
        logic [1:0]  btype;
        logic        exp_v;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic pcv, input logic [63:0] pc, input logic brv,
                                input logic misp, input logic taken, input logic [63:0] br_pc,
                                input logic [63:0] tgt, input logic [1:0] btype,
                                input logic exp_v, input logic [63:0] exp_pc);
        vec_t v;
        v.pcv = pcv; v.pc = pc; v.brv = brv; v.misp = misp; v.taken = taken;
        v.br_pc = br_pc; v.tgt = tgt; v.btype = btype; v.exp_v = exp_v; v.exp_pc = exp_pc;
        vecs.push_back(v);
    endfunction

    function automatic void look(input logic pcv, input logic [63:0] pc,
                                 input logic exp_v, input logic [63:0] exp_pc);
        add(pcv, pc, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, exp_v, exp_pc);
    endfunction

    task automatic apply(input vec_t v);
        io_pc_valid               = v.pcv;
        io_pc                     = v.pc;
        io_br_info_valid          = v.brv;
        io_br_info_mispredict     = v.misp;
        io_br_info_taken          = v.taken;
        io_br_info_br_pc          = v.br_pc;
        io_br_info_target_next_pc = v.tgt;
        io_br_info_br_type        = v.btype;
    endtask

    // Reference model: BTB entries remember the owning word address (pc>>2),
    // the RAS is an unbounded-looking queue trimmed to DEPTH from the old end.
    bit              m_v     [64];
    longint unsigned m_owner [64];
    longint unsigned m_tgt   [64];
    int              m_type  [64];
    int              m_pht   [64];
    longint unsigned m_ras[$];
    int              m_ghr;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0; m_pht[i] = 1;
        end
        m_ras.delete();
        m_ghr = 0;
    endfunction

    function automatic int pidx(input longint unsigned pc);
`ifdef BPU_GSHARE_EN
        return int'(((pc >> 3) ^ longint'(m_ghr)) % 64);
`else
        return int'((pc >> 3) % 64);
`endif
    endfunction

    function automatic void model_cycle(input vec_t v, output logic ev, output logic [63:0] epc);
        int              i;
        bit              hit;
        longint unsigned pc;
        longint unsigned bpc;
        pc  = v.pc;
        bpc = v.br_pc;
        i   = int'((pc >> 3) % 64);
        hit = m_v[i] && (m_owner[i] == (pc >> 2));
        ev  = 0;
        epc = 0;
        if (hit) ev = (m_type[i] == 0) ? (m_pht[pidx(pc)] >= 2) : 1'b1;
        if (ev) epc = (m_type[i] == 2 && m_ras.size() > 0) ? m_ras[$] : m_tgt[i];
        if (v.pcv && ev) begin
            if (m_type[i] == 1) begin
                m_ras.push_back(pc + 4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (m_type[i] == 2 && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        if (v.brv) begin
            if (v.misp) begin
                i = int'((bpc >> 3) % 64);
                m_v[i] = 1; m_owner[i] = bpc >> 2; m_tgt[i] = v.tgt; m_type[i] = int'(v.btype);
                m_ras.delete();
            end
            if (v.btype == 2'd0) begin
                i = pidx(bpc);
                if (v.taken) m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
                else         m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
                m_ghr = ((m_ghr << 1) | int'(v.taken)) % 64;
            end
        end
    endfunction

    function automatic logic [63:0] rpc();
        return 64'h8000_0000 + 64'(8 * $urandom_range(0, 7)) + 64'(4 * $urandom_range(0, 1))
               + 64'(32'h200 * $urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    localparam logic [63:0] RET_PC = 64'h8000_0200;

    initial begin
        vec_t v;
        logic ev;
        logic [63:0] epc;
        logic [63:0] cpc;

        vec_t idle;
        idle = '{pcv: 1'b0, pc: 64'd0, brv: 1'b0, misp: 1'b0, taken: 1'b0,
                 br_pc: 64'd0, tgt: 64'd0, btype: 2'd0, exp_v: 1'b0, exp_pc: 64'd0};
        apply(idle);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

`ifndef BPU_GSHARE_EN
        look(1, 64'h8000_0000, 0, 0);
        add(1, 64'h8000_0010, 1, 1, 1, 64'h8000_0010, 64'h8000_0100, 0, 0, 0);
        add(1, 64'h8000_0010, 1, 1, 1, 64'h8000_0010, 64'h8000_0100, 0, 1, 64'h8000_0100);
        look(1, 64'h8000_0010, 1, 64'h8000_0100);
        look(1, 64'h8000_0014, 0, 0);
        look(1, 64'h8000_0210, 0, 0);
        add(0, 0, 1, 1, 1, 64'h8000_0020, 64'h8000_0300, 1, 0, 0);
        add(0, 0, 1, 1, 1, RET_PC, 64'h8000_0400, 2, 0, 0);
        add(0, 0, 1, 1, 1, 64'h8000_0030, 64'h8000_0500, 3, 0, 0);
        look(1, 64'h8000_0030, 1, 64'h8000_0500);
        look(1, 64'h8000_0020, 1, 64'h8000_0300);
        look(0, RET_PC, 1, 64'h8000_0024);
        look(1, RET_PC, 1, 64'h8000_0024);
        look(1, RET_PC, 1, 64'h8000_0400);
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, 1, 1, 64'h8000_1040 + 64'(8 * k), 64'h8000_0700, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            look(1, 64'h8000_1040 + 64'(8 * k), 1, 64'h8000_0700);
        for (int k = 4; k >= 1; k--)
            look(1, RET_PC, 1, 64'h8000_1044 + 64'(8 * k));
        look(1, RET_PC, 1, 64'h8000_0400);
        add(1, 64'h8000_1040, 1, 1, 1, 64'h8000_0010, 64'h8000_0100, 0, 1, 64'h8000_0700);
        look(1, RET_PC, 1, 64'h8000_0400);
        add(1, 64'h8000_0010, 1, 0, 1, 64'h8000_0010, 0, 0, 1, 64'h8000_0100);
        add(1, 64'h8000_0010, 1, 0, 0, 64'h8000_0010, 0, 0, 1, 64'h8000_0100);
        add(1, 64'h8000_0010, 1, 0, 0, 64'h8000_0010, 0, 0, 1, 64'h8000_0100);
        add(1, 64'h8000_0010, 1, 0, 0, 64'h8000_0010, 0, 0, 0, 0);
        add(1, 64'h8000_0010, 1, 0, 0, 64'h8000_0010, 0, 0, 0, 0);
        add(1, 64'h8000_0010, 1, 0, 1, 64'h8000_0010, 0, 0, 0, 0);
        look(1, 64'h8000_0010, 0, 0);
        add(1, 64'h8000_0010, 1, 0, 1, 64'h8000_0010, 0, 3, 0, 0);
        add(1, 64'h8000_0010, 1, 0, 1, 64'h8000_0010, 0, 0, 0, 0);
        look(1, 64'h8000_0010, 1, 64'h8000_0100);
        add(1, 64'h8000_0010, 1, 1, 1, 64'h8000_0210, 64'h8000_0800, 0, 1, 64'h8000_0100);
        look(1, 64'h8000_0010, 0, 0);
        look(1, 64'h8000_0210, 1, 64'h8000_0800);
`else
        look(1, 64'h8000_0000, 0, 0);
        add(1, 64'h8000_0008, 1, 1, 1, 64'h8000_0008, 64'h8000_0100, 0, 0, 0);
        look(1, 64'h8000_0008, 0, 0);
        add(1, 64'h8000_0008, 1, 0, 1, 64'h8000_0008, 0, 0, 0, 0);
        look(1, 64'h8000_0008, 0, 0);
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clock);
            apply(vecs[n]);
            #1;
            check($sformatf("vec%0d_valid", n), 64'(io_pre_valid), 64'(vecs[n].exp_v));
            check($sformatf("vec%0d_next_pc", n), io_pre_next_pc, vecs[n].exp_pc);
        end

        apply(idle);
        do_reset();
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            v.pcv   = ($urandom_range(0, 3) != 0);
            v.pc    = rpc();
            v.brv   = $urandom_range(0, 1);
            v.misp  = ($urandom_range(0, 3) == 0);
            v.taken = $urandom_range(0, 1);
            v.br_pc = rpc();
            v.tgt   = {$urandom, $urandom};
            v.btype = 2'($urandom_range(0, 3));
            apply(v);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                model_reset();
                apply(idle);
                continue;
            end
            #1;
            model_cycle(v, ev, epc);
            check($sformatf("rnd%0d_valid", n), 64'(io_pre_valid), 64'(ev));
            check($sformatf("rnd%0d_next_pc", n), io_pre_next_pc, epc);
        end

        cpc = 64'h8000_0028;
        v = idle;
        v.brv = 1; v.misp = 1; v.btype = 2'd3; v.br_pc = cpc; v.tgt = 64'h8000_0900;
        @(negedge clock);
        apply(v);
        v = idle;
        v.pcv = 1; v.pc = cpc;
        @(negedge clock);
        apply(v);
        #1;
        check("pre_reset_hit", 64'(io_pre_valid), 64'd1);
        check("pre_reset_target", io_pre_next_pc, 64'h8000_0900);
        v.brv = 1; v.misp = 1; v.btype = 2'd3; v.br_pc = cpc; v.tgt = 64'h8000_0A00;
        @(negedge clock);
        apply(v);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        v = idle;
        v.pcv = 1; v.pc = cpc;
        apply(v);
        #1;
        check("post_reset_valid", 64'(io_pre_valid), 64'd0);
        check("post_reset_next_pc", io_pre_next_pc, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
